// File: rtl/alu_sequencer.sv
// Multi-cycle ALU execute controller: reads two operands through the register file's
// single port, computes an 8-bit result with zero/carry flags, then writes it back.
module alu_sequencer (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [2:0] i_op,
    input  logic [3:0] i_srcA,
    input  logic [3:0] i_srcB,
    input  logic [3:0] i_dst,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err,
    output logic [7:0] o_result,
    output logic       o_zero,
    output logic       o_carry,
    output logic       o_ldSig,
    output logic [3:0] o_regSel,
    output logic [7:0] o_regData,
    input  logic [7:0] i_regRdData
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RDA,
        S_RDB,
        S_EXEC,
        S_WB
    } state_t;

    state_t     state, state_nxt;
    logic [2:0] op_q;
    logic [3:0] src_a_q, src_b_q, dst_q;
    logic [7:0] opa_q;
    logic [8:0] alu_out;

    // Returns {carry, result}; carry is the borrow for SUB and the shifted-out bit for SHL.
    function automatic logic [8:0] alu(input logic [2:0] op, input logic [7:0] a,
                                       input logic [7:0] b);
        case (op)
            3'b000:  alu = {1'b0, a} + {1'b0, b};
            3'b001:  alu = {(a < b), 8'(a - b)};
            3'b010:  alu = {1'b0, a & b};
            3'b011:  alu = {1'b0, a | b};
            3'b100:  alu = {1'b0, a ^ b};
            3'b101:  alu = {1'b0, ~a};
            3'b110:  alu = {a[7], a[6:0], 1'b0};
            default: alu = {1'b0, a};
        endcase
    endfunction

    assign alu_out = alu(op_q, opa_q, i_regRdData);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= S_IDLE;
            o_done   <= 1'b0;
            o_err    <= 1'b0;
            o_result <= 8'h00;
            o_zero   <= 1'b0;
            o_carry  <= 1'b0;
        end else begin
            state  <= state_nxt;
            o_done <= (state == S_WB);
            o_err  <= (state == S_WB) && (dst_q > 4'd3);
            if (state == S_EXEC) begin
                o_result <= alu_out[7:0];
                o_zero   <= (alu_out[7:0] == 8'h00);
                o_carry  <= alu_out[8];
            end
        end
    end

    // Command fields and operand A carry no reset: they are only observed outside IDLE.
    always_ff @(posedge i_clk) begin
        if (state == S_IDLE && i_start) begin
            op_q    <= i_op;
            src_a_q <= i_srcA;
            src_b_q <= i_srcB;
            dst_q   <= i_dst;
        end
        if (state == S_RDB)
            opa_q <= i_regRdData;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_start) state_nxt = S_RDA;
            S_RDA:   state_nxt = S_RDB;
            S_RDB:   state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_WB;
            S_WB:    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Register file is addressed one cycle ahead of the data it returns.
    always_comb begin
        o_busy    = (state != S_IDLE);
        o_ldSig   = 1'b0;
        o_regSel  = 4'd0;
        o_regData = 8'h00;
        case (state)
            S_RDA:   o_regSel = src_a_q;
            S_RDB:   o_regSel = src_b_q;
            S_EXEC:  o_regSel = src_b_q;
            S_WB: begin
                o_regSel  = dst_q;
                o_regData = o_result;
                o_ldSig   = (dst_q <= 4'd3);
            end
            default: ;
        endcase
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle execute controller that sits directly upstream of the CPU register file. It accepts one ALU command (opcode, two source addresses, one destination address), reads both operands through the register file's single read/write port, computes an 8-bit result with zero/carry flags, and writes the result back. It owns the register file's load, select and write-data inputs and consumes its registered read-data output.

## Interface
Parameters: none (8-bit datapath, 4-bit register addresses fixed by the register file).
- i_clk  in  1  system clock; all state changes on rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_start  in  1  command strobe; accepted only in IDLE
- i_op  in  3  opcode, sampled with i_start
- i_srcA  in  4  operand A register address, sampled with i_start
- i_srcB  in  4  operand B register address, sampled with i_start
- i_dst  in  4  destination register address, sampled with i_start
- o_busy  out  1  high in every non-IDLE state
- o_done  out  1  one-cycle completion pulse
- o_err  out  1  valid with o_done: 1 = destination not writable, write suppressed
- o_result  out  8  last computed result, held until next EXEC
- o_zero  out  1  result == 0x00, held until next EXEC
- o_carry  out  1  carry/borrow flag, held until next EXEC
- o_ldSig  out  1  to register file load signal
- o_regSel  out  4  to register file address select
- o_regData  out  8  to register file write data
- i_regRdData  in  8  from register file registered read data

## Operation
- States: IDLE -> RDA -> RDB -> EXEC -> WB -> IDLE. Register-file-side outputs decode combinationally from state and latched fields.
- IDLE: o_ldSig=0, o_regSel=0, o_regData=0. On i_start, latch op/srcA/srcB/dst, go RDA. i_start in any other state is ignored (no queueing).
- RDA: o_regSel=srcA, o_ldSig=0. Register file registers A at the edge.
- RDB: o_regSel=srcB, o_ldSig=0. Capture i_regRdData (=A) into operand A at the edge.
- EXEC: o_regSel=srcB, o_ldSig=0. i_regRdData = B. Compute; register o_result, o_zero, o_carry at the edge.
- WB: o_regSel=dst, o_regData=o_result, o_ldSig = (dst <= 3). At the edge: o_done<=1, o_err<=(dst > 3), go IDLE.
- Opcodes (A, B unsigned 8-bit): 000 ADD A+B, carry = bit 8 of 9-bit sum; 001 SUB A-B mod 256, carry = (A < B) borrow; 010 AND; 011 OR; 100 XOR; 101 NOT A; 110 SHL A by 1, carry = A[7], LSB 0; 111 MOV A. Carry = 0 for 010-101 and 111.
- Sources may be any address; constants 8=0x00, 9=0x01, 10=0xFF; other non-writable addresses read 0x00.
- srcA == srcB and dst == srcA/srcB are legal; operands are read before write-back.

## Timing
- Reset (async, immediate): state=IDLE, o_busy=0, o_done=0, o_err=0, o_result=0x00, o_zero=0, o_carry=0; hence o_ldSig=0, o_regSel=0, o_regData=0 without waiting for a clock edge. Register-file contents are not reset by this block.
- Reset mid-command: command discarded, no write occurs if asserted before the WB edge, no o_done.
- Latency: i_start sampled at edge E0; o_busy high for 4 cycles (RDA, RDB, EXEC, WB); write occurs at edge E4; o_done and o_err high for the cycle after E4 only.
- Back-to-back: i_start in the o_done cycle (IDLE) is accepted; maximum throughput is one command per 5 cycles.
- o_err is 0 whenever o_done is 0.

## Test plan
- Reset: assert i_rst mid-cycle -> all outputs 0 immediately; after release with i_start=0, outputs stay 0 and o_busy=0.
- MOV r1<-r10, then ADD r2=r1+r9 -> first op writes 0xFF to r1; second o_result=0x00, o_zero=1, o_carry=1; MOV r3<-r2 reads back 0x00.
- SUB r0=r9-r10 -> o_result=0x02, o_carry=1, o_zero=0; SHL r0 (r0=0x81 preloaded via ADD 0x80+0x01) -> 0x02, carry=1.
- dst=8 with ADD r9+r9 -> o_ldSig never asserted; o_done=1 with o_err=1; o_result=0x02.
- i_start held high through an op -> second command accepted only in the o_done cycle; exactly 5 cycles between start edges; mid-op strobes ignored.
- Assert i_rst during WB with dst=2 -> o_ldSig drops immediately, r2 keeps old value, no o_done.
